// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
//   CNT_W_DEF       default divisor/counter width
//   DEFAULT_DIV_DEF default reset divisor (1 Hz at 100 MHz)
//   div_t           divisor/counter word at the default width
//   ch_state_t      per-channel state bundle
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 50_000_000;

    typedef logic [CNT_W_DEF-1:0] div_t;

    typedef struct packed {
        div_t cnt;
        div_t div_active;
        div_t shadow;
        logic pending;
        logic clk_out;
    } ch_state_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, shadowed divisor and outputs.
// Optional macro CLKDIV_SYNC_EN adds sync_in (phase-align and apply pending).
// Ports:
//   clk_in, rst      clock, synchronous active-high reset
//   sync_in          (CLKDIV_SYNC_EN only) global phase-align pulse
//   en               run enable
//   wr, wr_div       accepted divisor write (only raised while !pending)
//   clk_out, tick    divided square output and toggle strobe
//   pending          shadow divisor waiting to be applied
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] shadow;
    logic             sync_c;
    logic             wrap_c;
    logic             apply_c;

`ifdef CLKDIV_SYNC_EN
    assign sync_c = sync_in;
`else
    assign sync_c = 1'b0;
`endif

    // Wrap is the last cycle of a half-period; divisors are never zero.
    assign wrap_c  = en && (cnt == div_active - CNT_W'(1));
    // Pending divisor swaps only at a boundary: sync, idle, or wrap.
    assign apply_c = pending && (sync_c || !en || wrap_c);

    // Counter, output and shadow/pending state.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt        <= '0;
            div_active <= CNT_W'(DEFAULT_DIV);
            shadow     <= CNT_W'(DEFAULT_DIV);
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            if (sync_c || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (wrap_c) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick    <= 1'b0;
            end

            if (apply_c) begin
                div_active <= shadow;
            end

            // wr is only raised while !pending, so it never races apply_c.
            if (wr) begin
                shadow  <= (wr_div == '0) ? CNT_W'(1) : wr_div;
                pending <= 1'b1;
            end else if (apply_c) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Optional macro CLKDIV_SYNC_EN adds sync_in to phase-align all channels.
// Ports:
//   clk_in, rst        clock, synchronous active-high reset
//   sync_in            (CLKDIV_SYNC_EN only) align all channels
//   cfg_valid/ready    divisor write handshake (ready is combinational)
//   cfg_ch, cfg_div    target channel and new half-period (0 clamps to 1)
//   ch_en              per-channel run enable
//   clk_out, tick      per-channel square output and toggle strobe
//   busy               any channel has a pending divisor
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter  int unsigned N_CH        = 4,
    parameter  int unsigned CNT_W       = CNT_W_DEF,
    parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [N_CH-1:0]  ch_en,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic             busy
);

    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;

    // Channel decode; an out-of-range channel reads ready and is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        wr        = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
                wr[i]     = cfg_valid && !pending[i];
            end
        end
    end

    assign busy = |pending;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in  (clk_in),
            .rst     (rst),
`ifdef CLKDIV_SYNC_EN
            .sync_in (sync_in),
`endif
            .en      (ch_en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised scoreboard bench for clk_div_multi against a countdown model.
module tb_clk_div_multi;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned DEF_DIV = 5;
    localparam int unsigned CH_W    = 2;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic             busy;
`ifdef CLKDIV_SYNC_EN
    logic             sync_in;
`endif

    clk_div_multi #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
`ifdef CLKDIV_SYNC_EN
        .sync_in   (sync_in),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .ch_en     (ch_en),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [N_CH-1:0] out;
        logic [N_CH-1:0] tk;
        logic            bz;
        logic            rdy;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: each channel counts down the cycles left in its
    // current half-period and flips when the count is exhausted.
    int m_div  [N_CH];
    int m_sh   [N_CH];
    int m_rem  [N_CH];
    bit m_pend [N_CH];
    bit m_out  [N_CH];
    bit m_tick [N_CH];

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_div[i]  = DEF_DIV;
            m_sh[i]   = DEF_DIV;
            m_rem[i]  = DEF_DIV;
            m_pend[i] = 1'b0;
            m_out[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
    endtask

    function automatic bit m_ready();
        if (int'(cfg_ch) < N_CH) return !m_pend[int'(cfg_ch)];
        return 1'b1;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.bz  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            e.out[i] = m_out[i];
            e.tk[i]  = m_tick[i];
            e.bz     = e.bz | m_pend[i];
        end
        e.rdy = m_ready();
        sb.push_back(e);
    endtask

    task automatic model_step();
        bit acc;
        bit sy;
        int ach;
        if (rst) begin
            model_reset();
            return;
        end
        acc = cfg_valid && m_ready();
        ach = int'(cfg_ch);
        sy  = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sy  = sync_in;
`endif
        for (int i = 0; i < N_CH; i++) begin
            if (sy || !ch_en[i]) begin
                if (m_pend[i]) begin
                    m_div[i]  = m_sh[i];
                    m_pend[i] = 1'b0;
                end
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_rem[i]  = m_div[i];
            end else begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_out[i]  = !m_out[i];
                    m_tick[i] = 1'b1;
                    if (m_pend[i]) begin
                        m_div[i]  = m_sh[i];
                        m_pend[i] = 1'b0;
                    end
                    m_rem[i] = m_div[i];
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
        end
        if (acc && ach < N_CH) begin
            m_sh[ach]   = (cfg_div == 0) ? 1 : int'(cfg_div);
            m_pend[ach] = 1'b1;
        end
    endtask

    // One clock: record the expectation, advance the model, take the edge.
    task automatic cycle();
        push_exp();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic write(input int ch, input int dv);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cycle();
        cfg_valid = 1'b0;
    endtask

    // Monitor: compare DUT outputs at the falling edge.
    always @(negedge clk_in) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (clk_out !== e.out) begin
                n_err++;
                $display("FAIL clk_out at %0t: got %b exp %b", $time, clk_out, e.out);
            end
            if (tick !== e.tk) begin
                n_err++;
                $display("FAIL tick at %0t: got %b exp %b", $time, tick, e.tk);
            end
            if (busy !== e.bz) begin
                n_err++;
                $display("FAIL busy at %0t: got %b exp %b", $time, busy, e.bz);
            end
            if (cfg_ready !== e.rdy) begin
                n_err++;
                $display("FAIL cfg_ready at %0t: got %b exp %b", $time, cfg_ready, e.rdy);
            end
        end
    end

    initial begin
        int guard;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        ch_en     = '0;
`ifdef CLKDIV_SYNC_EN
        sync_in   = 1'b0;
`endif
        @(posedge clk_in);
        #1;
        model_reset();

        // Reset state, then channel 0 alone at the default divisor.
        run(3);
        rst   = 1'b0;
        ch_en = 4'b0001;
        run(25);

        // Mid-period shadow write, rejected second write, other-channel write.
        run(2);
        write(0, 3);
        write(0, 6);
        write(2, 2);
        run(30);

        // All channels on; ch1 retuned while others run.
        ch_en = 4'b1111;
        run(7);
        write(1, 2);
        run(20);

        // Drop ch0 while high, retune idle, re-enable.
        guard = 0;
        while (!m_out[0] && guard < 50) begin
            cycle();
            guard++;
        end
        if (guard >= 50) begin
            n_err++;
            $display("FAIL wait_ch0_high: got timeout exp clk_out[0]=1");
        end
        ch_en[0] = 1'b0;
        cycle();
        write(0, 4);
        run(3);
        ch_en[0] = 1'b1;
        run(15);
        write(3, 0);
        run(10);

        // Reset with pending writes outstanding.
        write(1, 7);
        write(2, 6);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(12);

`ifdef CLKDIV_SYNC_EN
        write(0, 3);
        write(1, 6);
        run(15);
        sync_in = 1'b1;
        cycle();
        sync_in = 1'b0;
        run(40);
`endif

        // Random traffic with small divisors to hit boundaries often.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 399) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CH_W'($urandom_range(0, N_CH - 1));
            cfg_div   = CNT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) ch_en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
`ifdef CLKDIV_SYNC_EN
            sync_in   = ($urandom_range(0, 99) == 0);
`endif
            cycle();
        end
        rst       = 1'b0;
        cfg_valid = 1'b0;
        run(2);

        @(negedge clk_in);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d left exp 0", sb.size());
        end
        if (n_vec == 0) begin
            n_err++;
            $display("FAIL vectors: got 0 exp >0");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider and tick generator; successor to the single fixed 1 Hz divider.
- N_CH independent channels, each with a runtime-programmable divisor, an enable, a 50 % square output and a single-cycle tick strobe.
- Divisor updates are shadowed and applied only at a period boundary, so outputs never glitch.
- Sits between the board clock and slow consumers: display refresh, debounce, and the quadrature sampling/rate logic.

Parameters:
- N_CH, 4, number of divider channels (1..16).
- CNT_W, 32, width of divisor and counter.
- DEFAULT_DIV, 50_000_000, divisor loaded into every channel at reset (1 Hz clk_out at 100 MHz clk_in).

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write can be accepted for channel cfg_ch
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel
- cfg_div  in  CNT_W  new half-period in clk_in cycles
- ch_en  in  N_CH  per-channel run enable
- clk_out  out  N_CH  divided square outputs
- tick  out  N_CH  one-cycle strobe at each clk_out toggle
- busy  out  1  OR of all pending-update flags

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst; it is sampled only at posedge clk_in.
- Reset state, all channels:
  - cnt = 0, clk_out = 0, tick = 0.
  - div_active = DEFAULT_DIV, pending = 0.
  - cfg_ready = 1, busy = 0.
- Reset asserted mid-operation discards all pending writes and returns to the reset state on the next edge.
- Enabled channel counting:
  - cnt increments each cycle.
  - When cnt == div_active-1 (the wrap cycle), the next edge sets cnt to 0, toggles clk_out and raises tick for exactly one cycle.
  - Output period = 2*div_active cycles. Duty = 50 %.
- Disabled channel (ch_en[i] = 0):
  - cnt is held at 0, clk_out is forced to 0 on the next edge, tick = 0.
  - On re-enable, the first toggle occurs div_active cycles after the cycle in which ch_en rose.
- cfg_div = 0 is clamped to 1. A divisor of 1 toggles clk_out every cycle, with tick held continuously high.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational).
  - A write is accepted when cfg_valid && cfg_ready; the value is stored in shadow[cfg_ch] and pending is set.
  - cfg_ch >= N_CH: the write is accepted and dropped.
- Applying a pending write:
  - Enabled channel: applied at the channel's next wrap cycle. div_active takes the new value, pending clears, and the next period uses the new divisor.
  - Disabled channel: applied on the next edge.
- Write accepted during a wrap cycle: the value becomes pending and is applied at the following wrap, not the current one.
- cnt compares against div_active only, so no wrap past div_active-1 is possible. Counter width is CNT_W with no overflow path.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined: adds input sync_in (1 bit). A high cycle does the following for all channels on the next edge:
  - cnt = 0, clk_out = 0, tick = 0.
  - Any pending divisor is applied immediately and pending clears.
  - This phase-aligns all outputs.
  - sync_in has priority over wrap; rst has priority over sync_in.
- Undefined: no sync_in port; channels are independent.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W_DEF and DEFAULT_DIV_DEF constants.
  - typedef div_t (logic [CNT_W-1:0]).
  - Per-channel state struct {cnt, div_active, shadow, pending, clk_out}.
- Sub-module clk_div_channel holds one channel's counter, shadow/pending logic and outputs. It is instantiated N_CH times by generate.
- The top level handles cfg decode, cfg_ready mux and busy OR.

Test Plan:
- Reset with DEFAULT_DIV = 5, ch_en = 4'b0001 → clk_out[0] toggles every 5 cycles (period 10), tick[0] high 1 cycle per toggle, other channels stay 0.
- While ch0 is running at div 5, write cfg_div = 3 mid-period → cfg_ready for ch0 goes low; current half-period still ends at 5; following half-periods are 3; pending clears at that wrap.
- Write ch1 cfg_div = 2 in the same cycle as ch1's wrap → the first period after it still uses the old divisor; div 2 applies from the next wrap.
- Second write to ch0 while pending → cfg_ready = 0, no acceptance; a write to ch2 in the same window is accepted.
- Deassert ch_en[0] while clk_out[0] = 1 → output 0 the next cycle; re-enable with div 4 → first toggle 4 cycles after ch_en rises. Writing cfg_div = 0 yields a per-cycle toggle.
- Assert rst mid-period with pending writes → all outputs 0, busy = 0, divisors back to DEFAULT_DIV. With CLKDIV_SYNC_EN, a sync_in pulse aligns ch0 (div 3) and ch1 (div 6) rising edges.
